// File: rtl/spi_register_decoder_if.sv
// Shifter <-> decoder handshake bundle: command/word pulses in, staged read response out.
interface spi_register_decoder_if #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned COMMAND_SIZE = 8
);
  logic [COMMAND_SIZE-1:0] command;
  logic                    command_ready;
  logic [WORD_SIZE-1:0]    word_received;
  logic                    word_rx_complete;
  logic [WORD_SIZE-1:0]    word_to_output;

  modport master (
    output command, command_ready, word_received, word_rx_complete,
    input  word_to_output
  );

  modport slave (
    input  command, command_ready, word_received, word_rx_complete,
    output word_to_output
  );
endinterface

// File: rtl/spi_register_decoder.sv
// Decodes SPI shifter commands into reads/writes of a small 32-bit register bank.
// Optional: define SPI_DECODER_LAST_WORD_EN for a read-only last-word capture register at 0x7F.
module spi_register_decoder #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned COMMAND_SIZE = 8,
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [31:0] DEVICE_ID    = 32'h50494356
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_register_decoder_if.slave   bus,
  output logic [WORD_SIZE-1:0]    ctrl_out,
  output logic                    write_strobe,
  output logic [COMMAND_SIZE-2:0] write_address,
  output logic [WORD_SIZE-1:0]    write_data,
  output logic                    error
);
  localparam int unsigned ADDR_W = COMMAND_SIZE - 1;
  localparam int unsigned GEN_N  = NUM_REGS - 5;
`ifdef SPI_DECODER_LAST_WORD_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
`endif

  typedef enum logic {IDLE, AWAIT_WORD} state_t;

  state_t              state, state_n;
  logic                pend_write, pend_write_n;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_n;
  logic [WORD_SIZE-1:0] scratch, scratch_n;
  logic [WORD_SIZE-1:0] ctrl_n;
  logic [WORD_SIZE-1:0] gen [GEN_N];
  logic [WORD_SIZE-1:0] gen_n [GEN_N];
  logic [2:0]          status, status_n;
  logic [WORD_SIZE-1:0] counter, counter_n;
  logic [WORD_SIZE-1:0] wto_n;
  logic                strobe_n;
  logic [ADDR_W-1:0]   waddr_n;
  logic [WORD_SIZE-1:0] wdata_n;
  logic [WORD_SIZE-1:0] rd_data_c;
  logic                rd_bad_c;
  logic                wr_ro_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
`ifdef SPI_DECODER_LAST_WORD_EN
  logic [WORD_SIZE-1:0] last_word, last_n;
`endif

  assign cmd_addr_c = bus.command[ADDR_W-1:0];

  // Word completion is applied first so a same-edge command sees its results.
  always_comb begin
    state_n      = state;
    pend_write_n = pend_write;
    pend_addr_n  = pend_addr;
    scratch_n    = scratch;
    ctrl_n       = ctrl_out;
    gen_n        = gen;
    status_n     = status;
    counter_n    = counter;
    wto_n        = bus.word_to_output;
    strobe_n     = 1'b0;
    waddr_n      = write_address;
    wdata_n      = write_data;
    rd_data_c    = '0;
    rd_bad_c     = 1'b0;
    wr_ro_c      = (pend_addr == ADDR_W'(0)) || (pend_addr == ADDR_W'(4));
`ifdef SPI_DECODER_LAST_WORD_EN
    last_n       = last_word;
    wr_ro_c      = wr_ro_c || (pend_addr == LAST_ADDR);
`endif

    if (bus.word_rx_complete) begin
      counter_n = counter + WORD_SIZE'(1);
`ifdef SPI_DECODER_LAST_WORD_EN
      last_n = bus.word_received;
`endif
      if (state == AWAIT_WORD) begin
        state_n = IDLE;
        if (pend_write) begin
          if (wr_ro_c) begin
            status_n[2] = 1'b1;
          end else if (pend_addr >= ADDR_W'(NUM_REGS)) begin
            status_n[0] = 1'b1;
          end else begin
            strobe_n = 1'b1;
            waddr_n  = pend_addr;
            wdata_n  = bus.word_received;
            if (pend_addr == ADDR_W'(1)) scratch_n = bus.word_received;
            else if (pend_addr == ADDR_W'(2)) ctrl_n = bus.word_received;
            else if (pend_addr == ADDR_W'(3)) status_n = status & ~bus.word_received[2:0];
            else begin
              for (int unsigned i = 0; i < GEN_N; i++) begin
                if (pend_addr == ADDR_W'(i + 5)) gen_n[i] = bus.word_received;
              end
            end
          end
        end
      end
    end

    if (bus.command_ready) begin
      // Cut-short write: new command arrived with no data word.
      if (state == AWAIT_WORD && !bus.word_rx_complete && pend_write) status_n[1] = 1'b1;
      state_n      = AWAIT_WORD;
      pend_write_n = bus.command[COMMAND_SIZE-1];
      pend_addr_n  = cmd_addr_c;

      if (cmd_addr_c == ADDR_W'(0)) rd_data_c = WORD_SIZE'(DEVICE_ID);
      else if (cmd_addr_c == ADDR_W'(1)) rd_data_c = scratch_n;
      else if (cmd_addr_c == ADDR_W'(2)) rd_data_c = ctrl_n;
      else if (cmd_addr_c == ADDR_W'(3)) rd_data_c = WORD_SIZE'(status_n);
      else if (cmd_addr_c == ADDR_W'(4)) rd_data_c = counter_n;
      else if (cmd_addr_c < ADDR_W'(NUM_REGS)) begin
        for (int unsigned i = 0; i < GEN_N; i++) begin
          if (cmd_addr_c == ADDR_W'(i + 5)) rd_data_c = gen_n[i];
        end
      end
`ifdef SPI_DECODER_LAST_WORD_EN
      else if (cmd_addr_c == LAST_ADDR) rd_data_c = last_n;
`endif
      else rd_bad_c = 1'b1;

      if (bus.command[COMMAND_SIZE-1]) begin
        wto_n = '0;
      end else begin
        wto_n = rd_data_c;
        if (rd_bad_c) status_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pend_write         <= 1'b0;
      pend_addr          <= '0;
      scratch            <= '0;
      ctrl_out           <= '0;
      for (int unsigned i = 0; i < GEN_N; i++) gen[i] <= '0;
      status             <= '0;
      counter            <= '0;
      bus.word_to_output <= '0;
      write_strobe       <= 1'b0;
      write_address      <= '0;
      write_data         <= '0;
      error              <= 1'b0;
`ifdef SPI_DECODER_LAST_WORD_EN
      last_word          <= '0;
`endif
    end else begin
      state              <= state_n;
      pend_write         <= pend_write_n;
      pend_addr          <= pend_addr_n;
      scratch            <= scratch_n;
      ctrl_out           <= ctrl_n;
      gen                <= gen_n;
      status             <= status_n;
      counter            <= counter_n;
      bus.word_to_output <= wto_n;
      write_strobe       <= strobe_n;
      write_address      <= waddr_n;
      write_data         <= wdata_n;
      error              <= |status;
`ifdef SPI_DECODER_LAST_WORD_EN
      last_word          <= last_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_register_decoder.sv
// Randomised self-checking bench for spi_register_decoder against a transaction-level register model.
module tb_spi_register_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ctrl_out;
  logic        write_strobe;
  logic [6:0]  write_address;
  logic [31:0] write_data;
  logic        error;

  spi_register_decoder_if #(.WORD_SIZE(32), .COMMAND_SIZE(8)) bus ();

  spi_register_decoder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ctrl_out(ctrl_out), .write_strobe(write_strobe),
    .write_address(write_address), .write_data(write_data), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Register-bank model: applies word then command per cycle, as a master would observe it.
  logic [31:0] m_mem [8];
  logic [2:0]  m_status;
  logic [31:0] m_cnt, m_last, m_wto, m_wdata;
  logic        m_pend, m_pw, m_strobe, m_err;
  logic [6:0]  m_pa, m_waddr;

  function automatic bit m_is_ro(input logic [6:0] a);
`ifdef SPI_DECODER_LAST_WORD_EN
    return (a == 7'd0) || (a == 7'd4) || (a == 7'h7F);
`else
    return (a == 7'd0) || (a == 7'd4);
`endif
  endfunction

  function automatic bit m_exists(input logic [6:0] a);
`ifdef SPI_DECODER_LAST_WORD_EN
    return (a < 7'd8) || (a == 7'h7F);
`else
    return a < 7'd8;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [6:0] a);
    if (a == 7'd0) return 32'h50494356;
    if (a == 7'd3) return {29'd0, m_status};
    if (a == 7'd4) return m_cnt;
    if (a == 7'h7F && m_exists(a)) return m_last;
    if (a < 7'd8) return m_mem[a[2:0]];
    return 32'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_status = '0; m_cnt = '0; m_last = '0; m_wto = '0; m_wdata = '0;
    m_pend = 0; m_pw = 0; m_strobe = 0; m_err = 0; m_pa = '0; m_waddr = '0;
  endtask

  task automatic m_word(input logic [31:0] w);
    m_cnt++;
    m_last = w;
    if (m_pend) begin
      m_pend = 0;
      if (m_pw) begin
        if (m_is_ro(m_pa)) m_status[2] = 1'b1;
        else if (!m_exists(m_pa)) m_status[0] = 1'b1;
        else begin
          m_strobe = 1; m_waddr = m_pa; m_wdata = w;
          if (m_pa == 7'd3) m_status = m_status & ~w[2:0];
          else m_mem[m_pa[2:0]] = w;
        end
      end
    end
  endtask

  task automatic m_cmd(input logic [7:0] c);
    if (m_pend && m_pw) m_status[1] = 1'b1;
    m_pend = 1; m_pw = c[7]; m_pa = c[6:0];
    if (c[7]) m_wto = '0;
    else begin
      m_wto = m_read(c[6:0]);
      if (!m_exists(c[6:0])) m_status[0] = 1'b1;
    end
  endtask

  // One clock of stimulus; model is advanced alongside.
  task automatic step(input bit cr, input logic [7:0] c, input bit wr, input logic [31:0] w);
    logic [2:0] prev;
    prev = m_status;
    m_strobe = 0;
    if (wr) m_word(w);
    if (cr) m_cmd(c);
    bus.command = c; bus.command_ready = cr;
    bus.word_received = w; bus.word_rx_complete = wr;
    @(posedge clk);
    #1;
    bus.command_ready = 0; bus.word_rx_complete = 0;
    m_err = |prev;
  endtask

  task automatic test_reset();
    bus.command_ready = 0; bus.word_rx_complete = 0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (bus.word_to_output !== 32'd0) begin errors++; $display("FAIL reset_wto: got %h expected 0", bus.word_to_output); end
    checks++; if (ctrl_out !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_out); end
    checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", write_strobe); end
    checks++; if (write_address !== 7'd0) begin errors++; $display("FAIL reset_waddr: got %h expected 0", write_address); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", write_data); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_id_read();
    step(1, 8'h00, 0, 0);
    checks++; if (bus.word_to_output !== 32'h50494356) begin errors++; $display("FAIL id_read: got %h expected %h", bus.word_to_output, 32'h50494356); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL id_error: got %b expected 0", error); end
  endtask

  task automatic test_write_read();
    step(1, 8'h81, 0, 0);
    step(0, 0, 1, 32'hA5A55A5A);
    checks++; if (write_strobe !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b expected 1", write_strobe); end
    checks++; if (write_address !== 7'h01) begin errors++; $display("FAIL wr_addr: got %h expected 01", write_address); end
    checks++; if (write_data !== 32'hA5A55A5A) begin errors++; $display("FAIL wr_data: got %h expected a5a55a5a", write_data); end
    step(0, 0, 0, 0);
    checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL wr_strobe_one_cycle: got %b expected 0", write_strobe); end
    step(1, 8'h01, 0, 0);
    checks++; if (bus.word_to_output !== 32'hA5A55A5A) begin errors++; $display("FAIL scratch_read: got %h expected a5a55a5a", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
  endtask

  task automatic test_ctrl_and_ro();
    step(1, 8'h82, 0, 0);
    step(0, 0, 1, 32'h000000FF);
    checks++; if (ctrl_out !== 32'h000000FF) begin errors++; $display("FAIL ctrl_out: got %h expected 000000ff", ctrl_out); end
    step(1, 8'h84, 0, 0);
    step(0, 0, 1, 32'h1);
    checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL ro_no_strobe: got %b expected 0", write_strobe); end
    step(0, 0, 0, 0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ro_error: got %b expected 1", error); end
    step(1, 8'h03, 0, 0);
    checks++; if (bus.word_to_output !== 32'h4) begin errors++; $display("FAIL ro_status: got %h expected 4", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
  endtask

  task automatic test_bad_addr_and_clear();
    step(1, 8'h10, 0, 0);
    checks++; if (bus.word_to_output !== 32'd0) begin errors++; $display("FAIL bad_read: got %h expected 0", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
    step(1, 8'h03, 0, 0);
    checks++; if (bus.word_to_output !== 32'h5) begin errors++; $display("FAIL bad_status: got %h expected 5", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
    step(1, 8'h83, 0, 0);
    step(0, 0, 1, 32'h7);
    checks++; if (write_strobe !== 1'b1) begin errors++; $display("FAIL w1c_strobe: got %b expected 1", write_strobe); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL w1c_error_lag: got %b expected 1", error); end
    step(0, 0, 0, 0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL w1c_error_clear: got %b expected 0", error); end
  endtask

  task automatic test_abort();
    step(1, 8'h81, 0, 0);
    step(1, 8'h01, 0, 0);
    checks++; if (bus.word_to_output !== m_mem[1]) begin errors++; $display("FAIL abort_scratch: got %h expected %h", bus.word_to_output, m_mem[1]); end
    step(1, 8'h03, 0, 0);
    checks++; if (bus.word_to_output !== 32'h2) begin errors++; $display("FAIL abort_status: got %h expected 2", bus.word_to_output); end
    step(1, 8'h83, 0, 0);
    step(0, 0, 1, 32'h7);
  endtask

  task automatic test_reset_midway();
    step(1, 8'h85, 0, 0);
    test_reset();
    step(0, 0, 1, 32'hDEADBEEF);
    checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL midreset_strobe: got %b expected 0", write_strobe); end
    step(1, 8'h05, 0, 0);
    checks++; if (bus.word_to_output !== 32'd0) begin errors++; $display("FAIL midreset_reg5: got %h expected 0", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
  endtask

  task automatic test_counter_last_word();
    test_reset();
    step(1, 8'h81, 0, 0); step(0, 0, 1, 32'h11);
    step(1, 8'h01, 0, 0); step(0, 0, 1, 32'h22);
    step(1, 8'h86, 0, 0); step(0, 0, 1, 32'h33);
    step(1, 8'h04, 0, 0);
    checks++; if (bus.word_to_output !== 32'd3) begin errors++; $display("FAIL counter: got %h expected 3", bus.word_to_output); end
    step(0, 0, 1, 32'h12345678);
    step(1, 8'h7F, 0, 0);
`ifdef SPI_DECODER_LAST_WORD_EN
    checks++; if (bus.word_to_output !== 32'h12345678) begin errors++; $display("FAIL last_word: got %h expected 12345678", bus.word_to_output); end
`else
    checks++; if (bus.word_to_output !== 32'd0) begin errors++; $display("FAIL last_word: got %h expected 0", bus.word_to_output); end
`endif
    step(0, 0, 1, 32'h0);
    step(1, 8'h03, 0, 0);
    checks++; if (bus.word_to_output !== {29'd0, m_status}) begin errors++; $display("FAIL last_word_status: got %h expected %h", bus.word_to_output, {29'd0, m_status}); end
    step(0, 0, 1, 32'h0);
  endtask

  task automatic test_back_to_back();
    step(1, 8'h81, 0, 0);
    step(1, 8'h01, 1, 32'hCAFEF00D);
    checks++; if (write_strobe !== 1'b1) begin errors++; $display("FAIL b2b_strobe: got %b expected 1", write_strobe); end
    checks++; if (bus.word_to_output !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_read: got %h expected cafef00d", bus.word_to_output); end
    step(1, 8'h03, 1, 32'h0);
    checks++; if (bus.word_to_output[1] !== 1'b0) begin errors++; $display("FAIL b2b_no_abort: got %h expected bit1 clear", bus.word_to_output); end
    step(0, 0, 1, 32'h0);
  endtask

  task automatic test_random();
    logic [6:0] addrs [11];
    logic [7:0] c;
    bit cr, wr;
    addrs = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'h10, 7'h7F};
    for (int n = 0; n < 400; n++) begin
      cr = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 2) != 0);
      c  = {1'($urandom_range(0, 1)), addrs[$urandom_range(0, 10)]};
      step(cr, c, wr, $urandom);
      checks++; if (bus.word_to_output !== m_wto) begin errors++; $display("FAIL rnd_wto[%0d]: got %h expected %h", n, bus.word_to_output, m_wto); end
      checks++; if (write_strobe !== m_strobe) begin errors++; $display("FAIL rnd_strobe[%0d]: got %b expected %b", n, write_strobe, m_strobe); end
      checks++; if (write_address !== m_waddr || write_data !== m_wdata) begin errors++; $display("FAIL rnd_wbus[%0d]: got %h/%h expected %h/%h", n, write_address, write_data, m_waddr, m_wdata); end
      checks++; if (ctrl_out !== m_mem[2]) begin errors++; $display("FAIL rnd_ctrl[%0d]: got %h expected %h", n, ctrl_out, m_mem[2]); end
      checks++; if (error !== m_err) begin errors++; $display("FAIL rnd_error[%0d]: got %b expected %b", n, error, m_err); end
    end
  endtask

  initial begin
    bus.command = '0; bus.command_ready = 0;
    bus.word_received = '0; bus.word_rx_complete = 0;
    #3;
    test_reset();
    test_id_read();
    test_write_read();
    test_ctrl_and_ro();
    test_bad_addr_and_clear();
    test_abort();
    test_reset_midway();
    test_counter_last_word();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
